// File: rtl/mfp_ahb_simple_master_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mfp_ahb_simple_master_pkg
// Brief   : AHB-Lite encodings and FSM states shared by the simple master.
// Revision: 1.0 - initial release
// ============================================================================
package mfp_ahb_simple_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Sizes above a word are never legal on this 32-bit bus.
  function automatic logic is_aligned(input logic [1:0] lsb, input logic [2:0] sz);
    case (sz)
      HSIZE_BYTE: return 1'b1;
      HSIZE_HALF: return ~lsb[0];
      HSIZE_WORD: return (lsb == 2'b00);
      default:    return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mfp_ahb_wait_timer.sv
`default_nettype none
// ============================================================================
// Module  : mfp_ahb_wait_timer
// Brief   : Counts consecutive HREADY-low cycles and flags the aborting one.
// Revision: 1.0 - initial release
// ============================================================================
module mfp_ahb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TIMEOUT_W      = 9
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic active,
  input  logic ready,
  output logic expire
);

  localparam logic [TIMEOUT_W-1:0] C_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] r_count;

  always_ff @(posedge HCLK) begin
    if (HRESET || !active || ready)
      r_count <= '0;
    else
      r_count <= r_count + TIMEOUT_W'(1);
  end

  // Fires during the TIMEOUT_CYCLES-th low cycle so the abort lands on its edge.
  assign expire = active && !ready && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/mfp_ahb_simple_master.sv
`default_nettype none
// ============================================================================
// Module  : mfp_ahb_simple_master
// Brief   : Single-outstanding AHB-Lite initiator, one SINGLE NONSEQ per req.
//           MFP_AHB_MASTER_TIMEOUT_EN enables the HREADY-low abort timer.
// Revision: 1.0 - initial release
// ============================================================================
module mfp_ahb_simple_master
  import mfp_ahb_simple_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TIMEOUT_W      = 9
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        req,
  output logic        ack,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        write,
  input  logic [2:0]  size,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        timeout,
  output logic        busy,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  state_t r_state;
  logic   r_timeout;
  logic   w_expire;

  if ((2 ** TIMEOUT_W) <= TIMEOUT_CYCLES) begin : g_bad_timeout_cfg
    $error("TIMEOUT_W too narrow for TIMEOUT_CYCLES");
  end

`ifdef MFP_AHB_MASTER_TIMEOUT_EN
  mfp_ahb_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_W      (TIMEOUT_W)
  ) u_wait_timer (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .active ((r_state == S_ADDR) || (r_state == S_DATA)),
    .ready  (HREADY),
    .expire (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  assign ack       = (r_state == S_IDLE) && req;
  assign timeout   = r_timeout;
  assign HBURST    = HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_DEFAULT;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state   <= S_IDLE;
      HTRANS    <= HTRANS_IDLE;
      HADDR     <= '0;
      HWDATA    <= '0;
      HWRITE    <= 1'b0;
      HSIZE     <= HSIZE_WORD;
      done      <= 1'b0;
      err       <= 1'b0;
      r_timeout <= 1'b0;
      rdata     <= '0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            busy      <= 1'b1;
            r_timeout <= 1'b0;
            if (is_aligned(addr[1:0], size)) begin
              r_state <= S_ADDR;
              HTRANS  <= HTRANS_NONSEQ;
              HADDR   <= addr;
              HWDATA  <= wdata;
              HWRITE  <= write;
              HSIZE   <= size;
              err     <= 1'b0;
            end else begin
              // Rejected locally: complete with an error, bus stays idle.
              r_state <= S_DONE;
              err     <= 1'b1;
              done    <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (w_expire) begin
            r_state   <= S_DONE;
            HTRANS    <= HTRANS_IDLE;
            err       <= 1'b1;
            r_timeout <= 1'b1;
            done      <= 1'b1;
          end else if (HREADY) begin
            r_state <= S_DATA;
            HTRANS  <= HTRANS_IDLE;
          end
        end
        S_DATA: begin
          // First error cycle has HREADY low, so it simply waits here.
          if (w_expire) begin
            r_state   <= S_DONE;
            err       <= 1'b1;
            r_timeout <= 1'b1;
            done      <= 1'b1;
          end else if (HREADY) begin
            if (!HWRITE)
              rdata <= HRDATA;
            err     <= HRESP;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mfp_ahb_simple_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_mfp_ahb_simple_master
// Brief   : Scoreboard bench for the AHB-Lite simple master with a task slave.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mfp_ahb_simple_master;

  localparam int          TMO      = 8;
  localparam logic [31:0] ERR_DATA = 32'hBAD0_0BAD;

  logic        HCLK = 1'b0;
  logic        HRESET, req, write, HREADY, HRESP;
  logic [31:0] addr, wdata, HRDATA;
  logic [2:0]  size;
  logic        ack, done, err, timeout, busy, HMASTLOCK, HWRITE;
  logic [31:0] rdata, HADDR, HWDATA;
  logic [2:0]  HBURST, HSIZE;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;

  typedef struct packed {
    logic [31:0] cyc;
    logic        err;
    logic        to;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [256];
  logic [31:0] m_rdata = '0;
  logic [31:0] cyc = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  mfp_ahb_simple_master #(.TIMEOUT_CYCLES(TMO), .TIMEOUT_W(9)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .req(req), .ack(ack), .addr(addr), .wdata(wdata),
    .write(write), .size(size), .done(done), .rdata(rdata), .err(err),
    .timeout(timeout), .busy(busy), .HADDR(HADDR), .HBURST(HBURST),
    .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HSIZE(HSIZE), .HTRANS(HTRANS),
    .HWDATA(HWDATA), .HWRITE(HWRITE), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  always @(negedge HCLK) begin
    if (!HRESET && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("err", {31'd0, err}, {31'd0, e.err});
        check("timeout", {31'd0, timeout}, {31'd0, e.to});
        check("rdata", rdata, e.rdata);
      end
    end
  end

  task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                      input logic [2:0] sz, input int aw, input int dw,
                      input bit eresp, input bit tmo);
    exp_t        e;
    bit          ok;
    logic [31:0] c0;
    ok = (sz == 3'd0) || (sz == 3'd1 && a[0] == 1'b0) || (sz == 3'd2 && a[1:0] == 2'b00);
    req = 1'b1; addr = a; wdata = wd; write = wr; size = sz;
    #1;
    check("ack", {31'd0, ack}, 32'd1);
    c0 = cyc;
    if (ok && !wr && !tmo) m_rdata = eresp ? ERR_DATA : mem[a[9:2]];
    e.err   = !ok || eresp || tmo;
    e.to    = tmo;
    e.rdata = m_rdata;
    e.cyc   = !ok ? c0 + 1 : tmo ? c0 + 1 + TMO : c0 + 3 + aw + dw + (eresp ? 1 : 0);
    sb.push_back(e);
    step();
    if (!ok) begin
      // req still high in the done cycle: must not be acknowledged
      check("ack_in_done", {31'd0, ack}, 32'd0);
      check("htrans_rejected", {30'd0, HTRANS}, 32'd0);
      req = 1'b0;
    end else begin
      req = 1'b0;
      for (int i = 0; i < (tmo ? TMO : aw + 1); i++) begin
        HREADY = (!tmo && i == aw);
        check("htrans_addr", {30'd0, HTRANS}, 32'd2);
        check("haddr", HADDR, a);
        check("hsize_hwrite", {28'd0, HWRITE, HSIZE}, {28'd0, wr, sz});
        step();
      end
      if (!tmo) begin
        for (int i = 0; i < dw + 1 + (eresp ? 1 : 0); i++) begin
          HREADY = (i == dw + (eresp ? 1 : 0));
          HRESP  = eresp;
          if (HREADY) begin
            if (eresp) HRDATA = ERR_DATA;
            else if (!wr) HRDATA = mem[a[9:2]];
            else if (sz == 3'd2) mem[a[9:2]] = HWDATA;
          end
          check("htrans_data", {30'd0, HTRANS}, 32'd0);
          check("hwdata", HWDATA, wd);
          check("haddr_data", HADDR, a);
          step();
        end
      end
      HREADY = 1'b1; HRESP = 1'b0;
      check("htrans_done", {30'd0, HTRANS}, 32'd0);
    end
    check("busy_done", {31'd0, busy}, 32'd1);
    step();
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("sb_drained", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
    HRESET = 1'b1; req = 1'b0; addr = '0; wdata = '0; write = 1'b0; size = '0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    repeat (3) step();
    check("rst_htrans", {30'd0, HTRANS}, 32'd0);
    check("rst_haddr", HADDR, 32'd0);
    check("rst_hsize", {29'd0, HSIZE}, 32'd2);
    check("rst_flags", {27'd0, done, err, timeout, busy, HWRITE}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_hwdata", HWDATA, 32'd0);
    check("const_bus", {24'd0, HBURST, HMASTLOCK, HPROT}, {24'd0, 3'b000, 1'b0, 4'b0011});
    HRESET = 1'b0;
    step();

    xfer(32'h10, 32'hDEADBEEF, 1'b1, 3'd2, 0, 0, 0, 0);
    xfer(32'h10, 32'h0,        1'b0, 3'd2, 0, 0, 0, 0);
    xfer(32'h14, 32'h12345678, 1'b1, 3'd2, 2, 2, 0, 0);
    xfer(32'h14, 32'h0,        1'b0, 3'd2, 2, 2, 0, 0);
    xfer(32'h20, 32'h0,        1'b0, 3'd2, 0, 0, 1, 0);
    xfer(32'h02, 32'h0,        1'b0, 3'd2, 0, 0, 0, 0);
    xfer(32'h00, 32'h0,        1'b0, 3'd3, 0, 0, 0, 0);
    xfer(32'h11, 32'h0,        1'b0, 3'd1, 0, 0, 0, 0);
    xfer(32'h12, 32'h0,        1'b0, 3'd1, 1, 0, 0, 0);
    xfer(32'h13, 32'hAB,       1'b1, 3'd0, 0, 1, 0, 0);

    // Reset lands in the data phase of a pending read
    req = 1'b1; addr = 32'h10; wdata = 32'h55; write = 1'b0; size = 3'd2;
    #1;
    check("ack_pre_rst", {31'd0, ack}, 32'd1);
    step();
    req = 1'b0; HREADY = 1'b1;
    step();
    HREADY = 1'b0; HRESET = 1'b1;
    step();
    check("mid_rst_htrans", {30'd0, HTRANS}, 32'd0);
    check("mid_rst_flags", {27'd0, done, err, timeout, busy, HWRITE}, 32'd0);
    check("mid_rst_haddr", HADDR, 32'd0);
    check("mid_rst_hwdata", HWDATA, 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    check("mid_rst_hsize", {29'd0, HSIZE}, 32'd2);
    HRESET = 1'b0; HREADY = 1'b1; m_rdata = '0;
    repeat (4) step();
    check("mid_rst_sb", sb.size(), 32'd0);
    xfer(32'h14, 32'h0, 1'b0, 3'd2, 0, 1, 0, 0);

`ifdef MFP_AHB_MASTER_TIMEOUT_EN
    xfer(32'h18, 32'h0, 1'b0, 3'd2, 0, 0, 0, 1);
    xfer(32'h10, 32'h0, 1'b0, 3'd2, 0, 0, 0, 0);
`endif

    step();
    check("final_sb", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
